instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Debug-path loader between the UART receiver and the MIPS core's instruction-memory write port. After a start pulse from the debug unit it collects received bytes, assembles them MSB-first into instruction words, and writes each word to consecutive instruction-memory addresses. Loading stops on the halt word or when memory is full, and completion is reported to the debug unit.

## Interface
- BITS_SIZE, 32, instruction word width; must be a multiple of SIZE_TRAMA
- SIZE_TRAMA, 8, UART byte width
- SIZE_MEM_INSTRUC, 256, instruction memory depth in words; ADDR_W = $clog2(SIZE_MEM_INSTRUC)
- HALT_WORD, 32'hFFFFFFFF, instruction value that terminates loading

Ports:
- i_clk  input  1  single clock
- i_reset  input  1  asynchronous, active-low reset
- i_start  input  1  one-cycle pulse from the debug unit; begins a load
- i_rx_done  input  1  one-cycle pulse; i_rx_data is valid
- i_rx_data  input  SIZE_TRAMA  received byte
- o_write_en  output  1  instruction-memory write strobe, one cycle per word
- o_addr  output  ADDR_W  write address
- o_data  output  BITS_SIZE  write data
- o_busy  output  1  high in LOAD and FLUSH
- o_done  output  1  one-cycle pulse at end of load
- o_overflow  output  1  sticky: memory filled before the halt word; cleared by i_start
- o_word_count  output  ADDR_W+1  words written in the current or last load

## Operation
- Bytes per word: BPW = BITS_SIZE/SIZE_TRAMA. Byte counter is $clog2(BPW) bits.
- Assembly: the shift register shifts left by SIZE_TRAMA on each accepted byte, so the first byte received ends in bits [BITS_SIZE-1:BITS_SIZE-SIZE_TRAMA].
- States are IDLE, LOAD, FLUSH and DONE.
- IDLE:
  - i_rx_done is ignored.
  - On i_start: clear the address, byte counter, o_word_count and o_overflow, then go to LOAD.
- LOAD:
  - Each i_rx_done accepts one byte.
  - On the BPW-th byte, the assembled word (including that byte) is latched into o_data.
  - o_write_en pulses on the next cycle at the current o_addr.
  - In that write cycle, o_addr increments and o_word_count increments.
- Termination after each write:
  - Latched word == HALT_WORD: that word is written; the state goes LOAD→FLUSH on the 4th-byte cycle, and FLUSH performs the write then goes to DONE.
  - Otherwise, if the write used address SIZE_MEM_INSTRUC-1: set o_overflow and go to DONE through FLUSH in the same way.
  - Otherwise: stay in LOAD.
- A byte arriving in the write cycle while in LOAD is accepted as byte 0 of the next word. No byte is lost.
- FLUSH: all bytes are ignored.
- DONE: o_done = 1 for one cycle, then IDLE. o_word_count and o_overflow hold until the next i_start.
- i_start outside IDLE is ignored.
- Address arithmetic wraps modulo SIZE_MEM_INSTRUC. o_word_count does not wrap: its maximum is SIZE_MEM_INSTRUC.

## Timing
- Reset (async, i_reset = 0):
  - State is IDLE.
  - o_write_en, o_busy, o_done and o_overflow are 0.
  - o_addr, o_data, o_word_count and the byte counter are 0.
- All outputs are registered, with no combinational path from input to output.
- i_start at cycle t: o_busy = 1 at t+1. The first byte is accepted from cycle t+1 onward.
- Last byte of a word (i_rx_done) at cycle t: o_write_en = 1 during t+1 with valid o_addr/o_data. o_addr advances at t+2.
- Halt or full: the last byte is at t, the write is at t+1 (FLUSH), o_done is at t+2 with o_busy = 0, and IDLE is reached at t+3.
- Reset asserted mid-load aborts immediately. A partial word is discarded and no write is issued.

## Test plan
- Reset values: hold i_reset = 0 with toggling inputs → all outputs 0. Release, then i_rx_done pulses without i_start → no o_write_en.
- Byte order: i_start, then bytes 12,34,56,78 → one write o_addr = 0, o_data = 32'h12345678, one cycle after the 4th byte.
- Multi-word with halt: words 8C010004, 00000000, FFFFFFFF → writes at addr 0,1,2; o_done pulse 2 cycles after the last byte; o_word_count = 3; o_overflow = 0.
- Back-to-back byte: first byte of word 2 is sent in the write cycle of word 1 → it is accepted; word 2 is correct at addr 1.
- Overflow: SIZE_MEM_INSTRUC = 4, five non-halt words → writes to addr 0..3; o_overflow = 1; o_done; the fifth word's bytes are ignored; o_word_count = 4.
- Reset mid-load: after 2 bytes of word 1 assert i_reset → no write. After release, i_start and a full halt word → written at addr 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Debug-path loader: assembles UART bytes MSB-first into instruction words and
// writes them to consecutive instruction-memory addresses until halt word or full.
module instr_mem_loader #(
  parameter int BITS_SIZE = 32,
  parameter int SIZE_TRAMA = 8,
  parameter int SIZE_MEM_INSTRUC = 256,
  parameter logic [BITS_SIZE-1:0] HALT_WORD = 32'hFFFFFFFF,
  localparam int ADDR_W = $clog2(SIZE_MEM_INSTRUC)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_rx_done,
  input  logic [SIZE_TRAMA-1:0] i_rx_data,
  output logic                  o_write_en,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [BITS_SIZE-1:0]  o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_W:0]       o_word_count,
  output logic [1:0]            o_state
);

  // Handshake: i_start and i_rx_done are single-cycle valid strobes with no
  // back-pressure; a byte is taken only in LOAD, everything else drops it.
  localparam int BPW = BITS_SIZE / SIZE_TRAMA;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE_MEM_INSTRUC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     byte_cnt;
  logic [BITS_SIZE-1:0] shift_reg;
  logic [BITS_SIZE-1:0] assembled;
  logic [ADDR_W-1:0]    addr_inc;
  logic [ADDR_W-1:0]    wr_addr;

  // wr_addr is the address the next latched word will use: if a write is in
  // flight this cycle, o_addr is about to advance past it.
  always_comb begin
    assembled = (shift_reg << SIZE_TRAMA) | BITS_SIZE'(i_rx_data);
    addr_inc  = (o_addr == LAST_ADDR) ? '0 : o_addr + ADDR_W'(1);
    wr_addr   = o_write_en ? addr_inc : o_addr;
  end

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      shift_reg    <= '0;
      o_write_en   <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_write_en <= 1'b0;
      o_done     <= 1'b0;
      if (o_write_en) begin
        o_addr       <= addr_inc;
        o_word_count <= o_word_count + (ADDR_W+1)'(1);
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            byte_cnt     <= '0;
            shift_reg    <= '0;
            o_addr       <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
            o_busy       <= 1'b1;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_rx_done) begin
            shift_reg <= assembled;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt   <= '0;
              o_data     <= assembled;
              o_write_en <= 1'b1;
              if (assembled == HALT_WORD) begin
                state <= S_FLUSH;
              end else if (wr_addr == LAST_ADDR) begin
                o_overflow <= 1'b1;
                state      <= S_FLUSH;
              end
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 256-word and a 4-word instance share stimulus and
// are checked against a byte-stream reference model.
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;

  logic        we_a, busy_a, done_a, ovf_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  cnt_a;
  logic [1:0]  state_a;
  logic        we_b, busy_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  cnt_b;
  logic [1:0]  state_b;

  instr_mem_loader dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .o_write_en(we_a), .o_addr(addr_a), .o_data(data_a), .o_busy(busy_a),
    .o_done(done_a), .o_overflow(ovf_a), .o_word_count(cnt_a), .o_state(state_a)
  );

  instr_mem_loader #(.SIZE_MEM_INSTRUC(4)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .o_write_en(we_b), .o_addr(addr_b), .o_data(data_b), .o_busy(busy_b),
    .o_done(done_b), .o_overflow(ovf_b), .o_word_count(cnt_b), .o_state(state_b)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int n_wr = 0;
  int start_cyc = -10;

  // reference model: per-instance load state, expected writes {cycle, addr, data}
  int          sz[2] = '{256, 4};
  bit          acc[2];
  int          bidx[2];
  logic [31:0] word[2];
  int          cnt[2];
  bit          ovf[2];
  int          done_at[2];
  logic [71:0] exp_q0[$];
  logic [71:0] exp_q1[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0; bidx[d] = 0; word[d] = '0; cnt[d] = 0; ovf[d] = 0; done_at[d] = -1;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_start();
    for (int d = 0; d < 2; d++) begin
      if (!acc[d]) begin
        acc[d] = 1; bidx[d] = 0; cnt[d] = 0; ovf[d] = 0;
      end
    end
  endtask

  task automatic model_byte(input int d, input logic [7:0] b);
    logic [71:0] e;
    if (!acc[d]) return;
    word[d] = {word[d][23:0], b};
    bidx[d]++;
    if (bidx[d] == 4) begin
      bidx[d] = 0;
      e = {32'(cyc + 1), 8'(cnt[d] % sz[d]), word[d]};
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
      cnt[d]++;
      if (word[d] == HALT) begin
        acc[d] = 0; done_at[d] = cyc + 2;
      end else if (cnt[d] == sz[d]) begin
        acc[d] = 0; ovf[d] = 1; done_at[d] = cyc + 2;
      end
    end
  endtask

  task automatic mon(input int d, input logic we, input logic [7:0] a, input logic [31:0] dt,
                     input logic dn, input logic bz, input logic [8:0] c, input logic ov);
    logic [71:0] e;
    if (we) begin
      n_wr++;
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        check($sformatf("d%0d_unexpected_write", d), 64'(1), 64'(0));
      end else begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("d%0d_wr_cycle", d), 64'(cyc), 64'(e[71:40]));
        check($sformatf("d%0d_wr_addr", d), 64'(a), 64'(e[39:32]));
        check($sformatf("d%0d_wr_data", d), 64'(dt), 64'(e[31:0]));
      end
    end
    if (dn) begin
      check($sformatf("d%0d_done_cycle", d), 64'(cyc), 64'(done_at[d]));
      check($sformatf("d%0d_done_busy", d), 64'(bz), 64'(0));
      check($sformatf("d%0d_done_count", d), 64'(c), 64'(cnt[d]));
      check($sformatf("d%0d_done_ovf", d), 64'(ov), 64'(ovf[d]));
      done_at[d] = -1;
    end
    if (cyc == start_cyc + 1) begin
      check($sformatf("d%0d_start_busy", d), 64'(bz), 64'(1));
      check($sformatf("d%0d_start_count", d), 64'(c), 64'(0));
      check($sformatf("d%0d_start_ovf", d), 64'(ov), 64'(0));
    end
  endtask

  always @(negedge i_clk) begin
    if (i_reset) begin
      mon(0, we_a, addr_a, data_a, done_a, busy_a, cnt_a, ovf_a);
      mon(1, we_b, {6'b0, addr_b}, data_b, done_b, busy_b, {6'b0, cnt_b}, ovf_b);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    step();
    i_rx_done = 1'b1;
    i_rx_data = b;
    model_byte(0, b);
    model_byte(1, b);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], $urandom_range(0, gap_max));
  endtask

  task automatic do_start();
    step();
    i_start = 1'b1;
    start_cyc = cyc;
    model_start();
  endtask

  task automatic finish_load(input string tag);
    repeat (6) step();
    check({tag, "_q0_empty"}, 64'(exp_q0.size()), 64'(0));
    check({tag, "_q1_empty"}, 64'(exp_q1.size()), 64'(0));
    check({tag, "_done_seen_a"}, 64'(done_at[0]), 64'(-1));
    check({tag, "_done_seen_b"}, 64'(done_at[1]), 64'(-1));
    check({tag, "_count_a"}, 64'(cnt_a), 64'(cnt[0]));
    check({tag, "_count_b"}, 64'(cnt_b), 64'(cnt[1]));
    check({tag, "_ovf_a"}, 64'(ovf_a), 64'(ovf[0]));
    check({tag, "_ovf_b"}, 64'(ovf_b), 64'(ovf[1]));
    check({tag, "_idle_busy_a"}, 64'(busy_a), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we_a"}, 64'(we_a), 64'(0));
    check({tag, "_addr_a"}, 64'(addr_a), 64'(0));
    check({tag, "_data_a"}, 64'(data_a), 64'(0));
    check({tag, "_busy_a"}, 64'(busy_a), 64'(0));
    check({tag, "_done_a"}, 64'(done_a), 64'(0));
    check({tag, "_ovf_a"}, 64'(ovf_a), 64'(0));
    check({tag, "_cnt_a"}, 64'(cnt_a), 64'(0));
    check({tag, "_state_a"}, 64'(state_a), 64'(0));
    check({tag, "_we_b"}, 64'(we_b), 64'(0));
    check({tag, "_busy_b"}, 64'(busy_b), 64'(0));
    check({tag, "_cnt_b"}, 64'(cnt_b), 64'(0));
    check({tag, "_state_b"}, 64'(state_b), 64'(0));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    int nw;
    model_reset();

    // reset held with toggling inputs
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk);
      #1;
      i_start = 1'($urandom_range(0, 1));
      i_rx_done = 1'($urandom_range(0, 1));
      i_rx_data = 8'($urandom);
    end
    step();
    check_zero("reset");
    i_reset = 1'b1;

    // bytes without a start are ignored
    wr_before = n_wr;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    repeat (4) step();
    check("idle_no_write", 64'(n_wr), 64'(wr_before));
    check("idle_busy", 64'(busy_a), 64'(0));

    // byte order, first byte in the cycle right after start
    do_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 1);
    send_byte(8'h78, 0);
    send_word(HALT, 1);
    finish_load("order");

    // multi-word with halt
    do_start();
    send_word(32'h8C010004, 2);
    send_word(32'h00000000, 2);
    send_word(HALT, 2);
    finish_load("halt3");
    check("halt3_count", 64'(cnt_a), 64'(3));

    // back-to-back bytes (next word's first byte lands in the write cycle),
    // with a stray start in the middle of the load
    do_start();
    send_word(32'hDEADBEEF, 0);
    send_byte(8'hA5, 0);
    step();
    i_start = 1'b1;
    model_start();
    send_byte(8'h5A, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_word(HALT, 0);
    finish_load("b2b");

    // small instance overflows after 4 words, big one halts after 6
    do_start();
    for (int i = 0; i < 5; i++) send_word(rand_word(), 1);
    send_word(HALT, 0);
    finish_load("ovf");
    check("ovf_small_flag", 64'(ovf_b), 64'(1));
    check("ovf_small_count", 64'(cnt_b), 64'(4));

    // randomized loads with noise bytes while idle
    for (int l = 0; l < 10; l++) begin
      do_start();
      nw = $urandom_range(1, 8);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 5) == 0) send_word(HALT, 3);
        else send_word(rand_word(), $urandom_range(0, 3));
      end
      send_word(HALT, 2);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      finish_load("rand");
    end

    // fill the full 256-word memory; the trailing word must be ignored
    do_start();
    for (int i = 0; i < 256; i++) send_word(rand_word(), 0);
    send_word(rand_word(), 0);
    finish_load("full");
    check("full_count", 64'(cnt_a), 64'(256));
    check("full_ovf", 64'(ovf_a), 64'(1));

    // reset in the middle of a word: no write, then a clean reload
    do_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    wr_before = n_wr;
    step();
    i_reset = 1'b0;
    model_reset();
    step();
    check_zero("midreset");
    check("midreset_no_write", 64'(n_wr), 64'(wr_before));
    i_reset = 1'b1;
    do_start();
    send_word(HALT, 1);
    finish_load("after_reset");
    check("after_reset_count", 64'(cnt_a), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
